// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: default operand width and FSM state encoding.
package serial_adder_pkg;

   localparam int DATA_WIDTH_DEFAULT = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used once per cycle by the serial adder datapath.
module full_adder (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = x ^ y ^ cin;
   assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one bit per cycle through a single full adder, LSB first.
// Handshake: start is sampled only in IDLE; done pulses for one cycle with resultado/carry_out valid.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] resultado,
   output logic                  carry_out,
   output logic [1:0]            fsm_state
);

   localparam int CW = $clog2(DATA_WIDTH + 1);

   state_t                state;
   state_t                state_next;
   logic [DATA_WIDTH-1:0] op_a;
   logic [DATA_WIDTH-1:0] op_b;
   // Partial sum holds the DATA_WIDTH-1 bits collected so far (requires DATA_WIDTH >= 2).
   logic [DATA_WIDTH-2:0] sum_q;
   logic [DATA_WIDTH-1:0] sum_next;
   logic                  carry_q;
   logic [CW-1:0]         count;
   logic                  last_bit;
   logic                  fa_s;
   logic                  fa_cout;

   full_adder u_full_adder (
      .x    (op_a[0]),
      .y    (op_b[0]),
      .cin  (carry_q),
      .s    (fa_s),
      .cout (fa_cout)
   );

   assign sum_next  = {fa_s, sum_q};
   assign last_bit  = (count == CW'(DATA_WIDTH - 1));
   assign busy      = (state == ADD);
   assign done      = (state == DONE);
   assign fsm_state = state;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = ADD;
         ADD:     if (last_bit) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         op_a      <= '0;
         op_b      <= '0;
         sum_q     <= '0;
         carry_q   <= 1'b0;
         count     <= '0;
         resultado <= '0;
         carry_out <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (start) begin
                  op_a    <= a;
                  op_b    <= b;
                  sum_q   <= '0;
                  carry_q <= 1'b0;
                  count   <= '0;
               end
            end
            ADD: begin
               op_a    <= op_a >> 1;
               op_b    <= op_b >> 1;
               sum_q   <= sum_next[DATA_WIDTH-1:1];
               carry_q <= fa_cout;
               count   <= count + CW'(1);
               // Outputs only change here so partial sums are never visible.
               if (last_bit) begin
                  resultado <= sum_next;
                  carry_out <= fa_cout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: latency, wrap-around, start handling, reset abort, full sweep.
module tb_serial_adder;

   localparam int W = 5;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] resultado;
   logic         carry_out;
   logic [1:0]   fsm_state;

   int           n_vec = 0;
   int           n_bad = 0;
   logic [W:0]   exp_q[$];
   logic [W:0]   last_res;

   serial_adder #(.DATA_WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .resultado (resultado),
      .carry_out (carry_out),
      .fsm_state (fsm_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one addition from IDLE; mid_x/mid_y replace the operands right after acceptance.
   task automatic run_add(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] mid_x, input logic [W-1:0] mid_y,
                          input logic [W:0] exp, input bit chk_lat, input string tag);
      int         lat;
      int         busy_cnt;
      bit         held_ok;
      logic [W:0] want;
      exp_q.push_back(exp);
      start = 1'b1;
      a     = x;
      b     = y;
      step();
      start    = 1'b0;
      a        = mid_x;
      b        = mid_y;
      lat      = 0;
      busy_cnt = 0;
      held_ok  = 1'b1;
      while (!done && lat < 20) begin
         if (busy) busy_cnt++;
         if (busy && done) held_ok = 1'b0;
         if ({carry_out, resultado} !== last_res) held_ok = 1'b0;
         step();
         lat++;
      end
      check({tag, "_done_seen"}, done, 1);
      want = exp_q.pop_front();
      check({tag, "_sum"}, {carry_out, resultado}, want);
      check({tag, "_no_partial"}, held_ok, 1);
      if (chk_lat) begin
         check({tag, "_latency"}, lat, W);
         check({tag, "_busy_cycles"}, busy_cnt, W);
         check({tag, "_busy_in_done"}, busy, 0);
      end
      last_res = {carry_out, resultado};
      step();
      if (chk_lat) check({tag, "_done_one_cycle"}, done, 0);
   endtask

   initial begin
      int   last_done;
      int   n_done;
      int   guard;
      bit   saw_done;

      rst   = 1'b1;
      start = 1'b1;
      a     = 5'd7;
      b     = 5'd9;
      step();
      step();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", {carry_out, resultado}, 0);
      check("rst_state", fsm_state, 0);
      last_res = '0;

      // Release reset with start already high: must be accepted at the first edge.
      rst = 1'b0;
      run_add(5'd3, 5'd4, 5'd3, 5'd4, 6'd7, 1'b1, "add_3_4");
      run_add(5'd31, 5'd1, 5'd31, 5'd1, 6'd32, 1'b1, "add_31_1");
      run_add(5'd31, 5'd31, 5'd31, 5'd31, 6'd62, 1'b1, "add_31_31");
      run_add(5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 1'b1, "add_0_0");

      // start held high: one done every 7 cycles.
      start     = 1'b1;
      a         = 5'd1;
      b         = 5'd1;
      last_done = -1;
      n_done    = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (done) begin
            n_done++;
            check("held_sum", {carry_out, resultado}, 2);
            if (last_done >= 0) check("held_interval", i - last_done, W + 2);
            last_done = i;
         end
      end
      check("held_done_count", n_done, 4);
      start = 1'b0;
      guard = 0;
      while ((busy || done) && guard < 20) begin
         step();
         guard++;
      end
      check("held_drain", guard < 20, 1);
      last_res = 6'd2;

      run_add(5'd5, 5'd6, 5'd9, 5'd9, 6'd11, 1'b1, "mid_change");

      // Abort with reset on the third ADD cycle.
      start = 1'b1;
      a     = 5'd10;
      b     = 5'd10;
      step();
      start = 1'b0;
      step();
      step();
      check("abort_busy_before", busy, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_sum", {carry_out, resultado}, 0);
      check("abort_state", fsm_state, 0);
      saw_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (done || busy) saw_done = 1'b1;
         step();
      end
      check("abort_quiet", saw_done, 0);
      last_res = '0;
      run_add(5'd10, 5'd10, 5'd10, 5'd10, 6'd20, 1'b1, "after_abort");

      for (int i = 0; i < 32; i++) begin
         for (int j = 0; j < 32; j++) begin
            run_add(W'(i), W'(j), W'(i), W'(j), 6'(i + j), 1'b0,
                    $sformatf("sweep_%0d_%0d", i, j));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
